// File: rtl/fch_pkg.sv
// Fetch-channel types and constants shared by the fetch unit and memory responders.
package fch_pkg;
  import isa_pkg::*;

  localparam logic [31:0] FCH_ILLEGAL_IR = 32'h0000_0000;
  localparam logic [31:0] FCH_RESET_PC   = 32'h4000_0000;

  typedef struct packed {
    logic [RV_PC_SIZE-1:0] pc;
  } fch_req_pkt_t;

  typedef struct packed {
    logic [RV_IR_SIZE-1:0] ir;
  } fch_rsp_pkt_t;
endpackage

// File: rtl/isa_pkg.sv
// ISA-wide sizing constants shared by every pipeline stage.
package isa_pkg;
  localparam int RV_PC_SIZE = 32;
  localparam int RV_IR_SIZE = 32;
endpackage

// File: rtl/fch_req_if_t.sv
// Fetch request channel: the fetch unit presents a PC, the memory side accepts it.
interface fch_req_if_t;
  import fch_pkg::*;

  logic         vld;
  logic         rdy;
  fch_req_pkt_t pkt;

  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/fch_rsp_if_t.sv
// Fetch response channel: the memory side returns the instruction word.
interface fch_rsp_if_t;
  import fch_pkg::*;

  logic         vld;
  logic         rdy;
  fch_rsp_pkt_t pkt;

  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/fch_rsp_fifo.sv
// In-order response FIFO; only the pointers and occupancy are reset, storage is not.
module fch_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_cnt;
  logic             w_doPush;
  logic             w_doPop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty  = (r_cnt == '0);
  assign o_full   = (r_cnt == CW'(DEPTH));
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;
  assign o_data   = r_mem[r_rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
      if (w_doPush && !w_doPop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_doPush && w_doPop) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end
endmodule

// File: rtl/imem_fch_slv.sv
// Instruction-memory fetch responder: word array, PC decode, fixed-latency read
// pipeline, credit-gated request acceptance and an in-order response FIFO.
module imem_fch_slv
  import fch_pkg::*;
#(
  parameter logic [31:0] BASE    = FCH_RESET_PC,
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 1,
  parameter int          OSTD    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  fch_req_if_t.slv                 fch_req_slv,
  fch_rsp_if_t.mst                 fch_rsp_mst,
  input  logic                     ld_vld,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(OSTD + 1);

  logic [31:0]   r_mem [DEPTH];
  logic [CW-1:0] r_ostdCnt;
  logic          w_reqRdy;
  logic          w_reqHsk;
  logic          w_rspHsk;
  logic [31:0]   w_off;
  logic          w_inRange;
  logic [AW-1:0] w_word;
  logic          w_unused;
  logic          w_push;
  logic [31:0]   w_pushIr;
  logic [31:0]   w_headIr;
  logic          w_fifoEmpty;
  logic          w_fifoFull;

  assign w_reqRdy        = (r_ostdCnt < CW'(OSTD));
  assign fch_req_slv.rdy = w_reqRdy;
  assign w_reqHsk        = fch_req_slv.vld & w_reqRdy;
  assign w_rspHsk        = ~w_fifoEmpty & fch_rsp_mst.rdy;

  // Byte offset from BASE; the two byte-select bits play no part in the lookup.
  assign w_off     = fch_req_slv.pkt.pc - BASE;
  assign w_inRange = (w_off[31:2] < 30'(DEPTH));
  assign w_word    = w_off[AW+1:2];
  assign w_unused  = ^w_off[1:0];

  always_ff @(posedge clk) begin
    if (ld_vld) r_mem[ld_addr] <= ld_data;
  end

  // The array read happens at the handshake edge, so a same-cycle load is not yet visible.
  if (LATENCY == 1) begin : g_lat1
    assign w_push   = w_reqHsk;
    assign w_pushIr = w_inRange ? r_mem[w_word] : FCH_ILLEGAL_IR;
  end else begin : g_pipe
    localparam int NS = LATENCY - 1;
    logic [NS-1:0] r_vld;
    logic [NS-1:0] r_oor;
    logic [31:0]   r_data [NS];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld <= '0;
        r_oor <= '0;
      end else begin
        r_vld[0] <= w_reqHsk;
        r_oor[0] <= ~w_inRange;
        for (int i = 1; i < NS; i++) begin
          r_vld[i] <= r_vld[i-1];
          r_oor[i] <= r_oor[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (w_reqHsk && w_inRange) r_data[0] <= r_mem[w_word];
      for (int i = 1; i < NS; i++) r_data[i] <= r_data[i-1];
    end

    assign w_push   = r_vld[NS-1];
    assign w_pushIr = r_oor[NS-1] ? FCH_ILLEGAL_IR : r_data[NS-1];
  end

  fch_rsp_fifo #(.DEPTH(OSTD), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_pushIr),
    .i_pop   (w_rspHsk),
    .o_data  (w_headIr),
    .o_empty (w_fifoEmpty),
    .o_full  (w_fifoFull)
  );

  assign fch_rsp_mst.vld    = ~w_fifoEmpty;
  assign fch_rsp_mst.pkt.ir = w_headIr;

  // Credits cover both the read pipeline and the FIFO, so a push never meets a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ostdCnt <= '0;
    end else begin
      case ({w_reqHsk, w_rspHsk})
        2'b10:   r_ostdCnt <= r_ostdCnt + 1'b1;
        2'b01:   r_ostdCnt <= r_ostdCnt - 1'b1;
        default: r_ostdCnt <= r_ostdCnt;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) r_ostdCnt <= CW'(OSTD));
  assert property (@(posedge clk) disable iff (rst) !(w_rspHsk && r_ostdCnt == '0));
  assert property (@(posedge clk) disable iff (rst) !(w_push && w_fifoFull));
endmodule

// File: tb/tb_imem_fch_slv.sv
// Directed bench for imem_fch_slv: one instance at LATENCY=1 and one at LATENCY=2.
module tb_imem_fch_slv;
  import fch_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] W0 = 32'h0050_0093;
  localparam logic [31:0] W1 = 32'h00a0_0113;
  localparam logic [31:0] W2 = 32'h00f0_0193;
  localparam logic [31:0] W3 = 32'h0140_0213;

  logic clk = 1'b0;
  logic rst;
  logic ldVld;
  logic [11:0] ldAddr;
  logic [31:0] ldData;
  logic [31:0] expW [4] = '{W0, W1, W2, W3};
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fch_req_if_t reqA ();
  fch_rsp_if_t rspA ();
  fch_req_if_t reqB ();
  fch_rsp_if_t rspB ();

  imem_fch_slv #(.BASE(BASE), .DEPTH(4096), .LATENCY(1), .OSTD(2)) dutA (
    .clk(clk), .rst(rst), .fch_req_slv(reqA), .fch_rsp_mst(rspA),
    .ld_vld(ldVld), .ld_addr(ldAddr), .ld_data(ldData)
  );

  imem_fch_slv #(.BASE(BASE), .DEPTH(4096), .LATENCY(2), .OSTD(2)) dutB (
    .clk(clk), .rst(rst), .fch_req_slv(reqB), .fch_rsp_mst(rspB),
    .ld_vld(ldVld), .ld_addr(ldAddr), .ld_data(ldData)
  );

  task automatic loadWord(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    ldVld = 1'b1; ldAddr = a; ldData = d;
    @(negedge clk);
    ldVld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ldVld = 1'b0; ldAddr = '0; ldData = '0;
    reqA.vld = 1'b0; reqA.pkt.pc = '0; rspA.rdy = 1'b0;
    reqB.vld = 1'b0; reqB.pkt.pc = '0; rspB.rdy = 1'b0;
    repeat (2) @(negedge clk);
    if (reqA.rdy !== 1'b1) begin errors++; $display("[TB] FAIL rst_rdyA got=%b want=1", reqA.rdy); end
    checks++;
    if (rspA.vld !== 1'b0) begin errors++; $display("[TB] FAIL rst_vldA got=%b want=0", rspA.vld); end
    checks++;
    if (dutA.r_ostdCnt !== 2'd0) begin errors++; $display("[TB] FAIL rst_cntA got=%0d want=0", dutA.r_ostdCnt); end
    checks++;
    if (reqB.rdy !== 1'b1) begin errors++; $display("[TB] FAIL rst_rdyB got=%b want=1", reqB.rdy); end
    checks++;
    if (rspB.vld !== 1'b0) begin errors++; $display("[TB] FAIL rst_vldB got=%b want=0", rspB.vld); end
    checks++;
    rst = 1'b0;
  endtask

  task automatic test_basic_fetch();
    for (int k = 0; k < 4; k++) loadWord(12'(k), expW[k]);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        if (rspA.vld !== 1'b1 || rspA.pkt.ir !== expW[k-1]) begin
          errors++; $display("[TB] FAIL basic_rsp%0d got vld=%b ir=%h want vld=1 ir=%h", k-1, rspA.vld, rspA.pkt.ir, expW[k-1]);
        end
        checks++;
      end
      if (k < 4) begin
        if (reqA.rdy !== 1'b1) begin errors++; $display("[TB] FAIL basic_rdy%0d got=%b want=1", k, reqA.rdy); end
        checks++;
      end
      reqA.vld = (k < 4);
      reqA.pkt.pc = BASE + 32'(4 * k);
      rspA.rdy = 1'b1;
    end
    @(negedge clk);
    if (rspA.vld !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain got=%b want=0", rspA.vld); end
    checks++;
    rspA.rdy = 1'b0;
  endtask

  task automatic test_backpressure();
    rspB.rdy = 1'b0;
    @(negedge clk);
    if (reqB.rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_rdy0 got=%b want=1", reqB.rdy); end
    checks++;
    reqB.vld = 1'b1; reqB.pkt.pc = BASE;
    @(negedge clk);
    if (reqB.rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_rdy1 got=%b want=1", reqB.rdy); end
    checks++;
    reqB.pkt.pc = BASE + 32'd4;
    @(negedge clk);
    if (reqB.rdy !== 1'b0) begin errors++; $display("[TB] FAIL bp_rdy_drop got=%b want=0", reqB.rdy); end
    checks++;
    reqB.pkt.pc = BASE + 32'd8;
    @(negedge clk);
    if (reqB.rdy !== 1'b0) begin errors++; $display("[TB] FAIL bp_rdy_hold got=%b want=0", reqB.rdy); end
    checks++;
    if (rspB.vld !== 1'b1 || rspB.pkt.ir !== W0) begin errors++; $display("[TB] FAIL bp_ir0 got vld=%b ir=%h want vld=1 ir=%h", rspB.vld, rspB.pkt.ir, W0); end
    checks++;
    rspB.rdy = 1'b1;
    @(negedge clk);
    if (rspB.vld !== 1'b1 || rspB.pkt.ir !== W1) begin errors++; $display("[TB] FAIL bp_ir1 got vld=%b ir=%h want vld=1 ir=%h", rspB.vld, rspB.pkt.ir, W1); end
    checks++;
    if (reqB.rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_rdy_reopen got=%b want=1", reqB.rdy); end
    checks++;
    @(negedge clk);
    reqB.vld = 1'b0;
    if (rspB.vld !== 1'b0) begin errors++; $display("[TB] FAIL bp_gap got=%b want=0", rspB.vld); end
    checks++;
    if (dutB.r_ostdCnt !== 2'd1) begin errors++; $display("[TB] FAIL bp_cnt got=%0d want=1", dutB.r_ostdCnt); end
    checks++;
    @(negedge clk);
    if (rspB.vld !== 1'b1 || rspB.pkt.ir !== W2) begin errors++; $display("[TB] FAIL bp_ir2 got vld=%b ir=%h want vld=1 ir=%h", rspB.vld, rspB.pkt.ir, W2); end
    checks++;
    @(negedge clk);
    if (rspB.vld !== 1'b0 || dutB.r_ostdCnt !== 2'd0) begin errors++; $display("[TB] FAIL bp_idle got vld=%b cnt=%0d want vld=0 cnt=0", rspB.vld, dutB.r_ostdCnt); end
    checks++;
    rspB.rdy = 1'b0;
  endtask

  task automatic test_simultaneous();
    rspA.rdy = 1'b0;
    @(negedge clk);
    reqA.vld = 1'b1; reqA.pkt.pc = BASE;
    @(negedge clk);
    reqA.pkt.pc = BASE + 32'd4;
    @(negedge clk);
    if (reqA.rdy !== 1'b0 || dutA.r_ostdCnt !== 2'd2) begin errors++; $display("[TB] FAIL sim_full got rdy=%b cnt=%0d want rdy=0 cnt=2", reqA.rdy, dutA.r_ostdCnt); end
    checks++;
    if (rspA.pkt.ir !== W0) begin errors++; $display("[TB] FAIL sim_ir0 got=%h want=%h", rspA.pkt.ir, W0); end
    checks++;
    reqA.pkt.pc = BASE + 32'd8;
    rspA.rdy = 1'b1;
    @(negedge clk);
    if (reqA.rdy !== 1'b1 || dutA.r_ostdCnt !== 2'd1) begin errors++; $display("[TB] FAIL sim_pop got rdy=%b cnt=%0d want rdy=1 cnt=1", reqA.rdy, dutA.r_ostdCnt); end
    checks++;
    if (rspA.pkt.ir !== W1) begin errors++; $display("[TB] FAIL sim_ir1 got=%h want=%h", rspA.pkt.ir, W1); end
    checks++;
    @(negedge clk);
    if (dutA.r_ostdCnt !== 2'd1) begin errors++; $display("[TB] FAIL sim_cnt_hold got=%0d want=1", dutA.r_ostdCnt); end
    checks++;
    if (rspA.vld !== 1'b1 || rspA.pkt.ir !== W2) begin errors++; $display("[TB] FAIL sim_ir2 got vld=%b ir=%h want vld=1 ir=%h", rspA.vld, rspA.pkt.ir, W2); end
    checks++;
    reqA.vld = 1'b0;
    @(negedge clk);
    if (rspA.vld !== 1'b0 || dutA.r_ostdCnt !== 2'd0) begin errors++; $display("[TB] FAIL sim_idle got vld=%b cnt=%0d want vld=0 cnt=0", rspA.vld, dutA.r_ostdCnt); end
    checks++;
    rspA.rdy = 1'b0;
  endtask

  task automatic test_out_of_range();
    loadWord(12'hFFF, 32'h1234_5678);
    @(negedge clk);
    reqA.vld = 1'b1; reqA.pkt.pc = 32'h3FFF_FFFC; rspA.rdy = 1'b1;
    @(negedge clk);
    if (rspA.vld !== 1'b1 || rspA.pkt.ir !== FCH_ILLEGAL_IR) begin errors++; $display("[TB] FAIL oor_below got vld=%b ir=%h want vld=1 ir=00000000", rspA.vld, rspA.pkt.ir); end
    checks++;
    reqA.pkt.pc = BASE + 32'h0000_4000;
    @(negedge clk);
    if (rspA.vld !== 1'b1 || rspA.pkt.ir !== FCH_ILLEGAL_IR) begin errors++; $display("[TB] FAIL oor_above got vld=%b ir=%h want vld=1 ir=00000000", rspA.vld, rspA.pkt.ir); end
    checks++;
    reqA.vld = 1'b0;
    @(negedge clk);
    rspA.rdy = 1'b0;
  endtask

  task automatic test_load_collision();
    loadWord(12'd5, 32'h1111_1111);
    @(negedge clk);
    ldVld = 1'b1; ldAddr = 12'd5; ldData = 32'hDEAD_BEEF;
    reqA.vld = 1'b1; reqA.pkt.pc = BASE + 32'd20; rspA.rdy = 1'b1;
    @(negedge clk);
    ldVld = 1'b0;
    if (rspA.vld !== 1'b1 || rspA.pkt.ir !== 32'h1111_1111) begin errors++; $display("[TB] FAIL coll_old got vld=%b ir=%h want vld=1 ir=11111111", rspA.vld, rspA.pkt.ir); end
    checks++;
    @(negedge clk);
    if (rspA.vld !== 1'b1 || rspA.pkt.ir !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL coll_new got vld=%b ir=%h want vld=1 ir=deadbeef", rspA.vld, rspA.pkt.ir); end
    checks++;
    reqA.vld = 1'b0;
    @(negedge clk);
    rspA.rdy = 1'b0;
  endtask

  task automatic test_reset_midrun();
    rspB.rdy = 1'b1;
    @(negedge clk);
    reqB.vld = 1'b1; reqB.pkt.pc = BASE + 32'd4;
    @(negedge clk);
    reqB.vld = 1'b0;
    rst = 1'b1;
    #1;
    if (reqB.rdy !== 1'b1 || rspB.vld !== 1'b0 || dutB.r_ostdCnt !== 2'd0) begin
      errors++; $display("[TB] FAIL mid_rst got rdy=%b vld=%b cnt=%0d want rdy=1 vld=0 cnt=0", reqB.rdy, rspB.vld, dutB.r_ostdCnt);
    end
    checks++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rspB.vld !== 1'b0) begin errors++; $display("[TB] FAIL mid_dropped%0d got=%b want=0", k, rspB.vld); end
      checks++;
    end
    reqB.vld = 1'b1; reqB.pkt.pc = BASE + 32'd8;
    @(negedge clk);
    reqB.vld = 1'b0;
    @(negedge clk);
    if (rspB.vld !== 1'b1 || rspB.pkt.ir !== W2) begin errors++; $display("[TB] FAIL mid_retained got vld=%b ir=%h want vld=1 ir=%h", rspB.vld, rspB.pkt.ir, W2); end
    checks++;
    @(negedge clk);
    rspB.rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_simultaneous();
    test_out_of_range();
    test_load_collision();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
